// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser and arbiter state encodings, frame
// format constants and a helper to derive the bit period from clock/baud.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } ser_state_t;

   typedef enum logic {
      ARB  = 1'b0,
      SEND = 1'b1
   } arb_state_t;

   // Rounded to the nearest integer so the bit-rate error stays minimal.
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + (baud / 2)) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 UART transmit serialiser.
//   i_Clk    : clock
//   i_Rst_L  : asynchronous active-low reset, returns to IDLE with line high
//   i_Start  : accepted in IDLE only; i_Byte is captured on the same edge
//   i_Byte   : byte to send, LSB first
//   o_TX     : serial line, driven directly from a flop, idles high
//   o_Busy   : high whenever a frame is in progress
//   o_Done   : one-cycle pulse during the last cycle of the stop bit
//
// state | meaning
// IDLE  | line high, waiting for i_Start
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (line high) for CLKS_PER_BIT cycles
module uart_tx_serial
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Start,
   input  logic [7:0] i_Byte,
   output logic       o_TX,
   output logic       o_Busy,
   output logic       o_Done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   ser_state_t       state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_byte;
   logic             bit_end;

   assign bit_end = (baud_cnt == '0);
   assign o_Busy  = (state != IDLE);
   // Decoded from flops: tells the arbiter to release on the next edge, so
   // the cycle after the stop bit is the arbitration cycle.
   assign o_Done  = (state == STOP) && bit_end;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= IDLE;
         o_TX       <= 1'b1;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_byte <= '0;
      end else begin
         case (state)
            IDLE: begin
               o_TX <= 1'b1;
               if (i_Start) begin
                  shift_byte <= i_Byte;
                  o_TX       <= 1'b0;
                  baud_cnt   <= CNT_RELOAD;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  o_TX       <= shift_byte[0];
                  shift_byte <= shift_byte >> 1;
                  bit_idx    <= '0;
                  baud_cnt   <= CNT_RELOAD;
                  state      <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= CNT_RELOAD;
                  if (bit_idx == LAST_BIT) begin
                     o_TX  <= 1'b1;
                     state <= STOP;
                  end else begin
                     o_TX       <= shift_byte[0];
                     shift_byte <= shift_byte >> 1;
                     bit_idx    <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               o_TX  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line among NUM_REQ requesters.
//   i_Clk        : clock
//   i_Rst_L      : asynchronous active-low reset; aborts any frame in flight
//   i_Req        : per-requester request, held with data stable until acked
//   i_Data       : requester k's byte in bits [8k+7:8k]
//   o_Ack        : one-hot single-cycle pulse when a requester's byte is taken
//   o_Busy       : high while a frame is in flight
//   o_Active_Idx : index of the current/last granted requester
//   o_UART_TX    : serial line (idles high)
//
// state | meaning
// ARB   | line idle; grant on any edge with a pending request
// SEND  | frame in flight; requests ignored until the serialiser is done
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 217
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst_L,
   input  logic [NUM_REQ-1:0]         i_Req,
   input  logic [8*NUM_REQ-1:0]       i_Data,
   output logic [NUM_REQ-1:0]         o_Ack,
   output logic                       o_Busy,
   output logic [$clog2(NUM_REQ)-1:0] o_Active_Idx,
   output logic                       o_UART_TX
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_valid;
   logic [7:0]       sel_byte;
   logic             grant;
   logic             ser_busy;
   logic             ser_done;
   logic [7:0]       req_byte [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_byte[g] = i_Data[8*g +: 8];
   end

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int off);
      int k;
      k = int'(base) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      return IDX_W'(k);
   endfunction

   // First pending request at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = rr_index(ptr, i);
         if (!sel_valid && i_Req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
      sel_byte = req_byte[sel_idx];
   end

   // The serialiser starts on the grant edge itself so the start bit
   // coincides with the ack cycle.
   assign grant = (state == ARB) && sel_valid && !ser_busy;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= ARB;
         ptr          <= '0;
         o_Ack        <= '0;
         o_Busy       <= 1'b0;
         o_Active_Idx <= '0;
      end else begin
         o_Ack <= '0;
         case (state)
            ARB: begin
               if (grant) begin
                  o_Ack        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                  o_Active_Idx <= sel_idx;
                  ptr          <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                  o_Busy       <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               if (ser_done) begin
                  o_Busy <= 1'b0;
                  state  <= ARB;
               end
            end
            default: begin
               o_Busy <= 1'b0;
               state  <= ARB;
            end
         endcase
      end
   end

   uart_tx_serial #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_serial (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Start (grant),
      .i_Byte  (sel_byte),
      .o_TX    (o_UART_TX),
      .o_Busy  (ser_busy),
      .o_Done  (ser_done)
   );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  ack;
   logic        busy;
   logic [1:0]  act_idx;
   logic        tx;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   uart_tx_arbiter #(
      .NUM_REQ      (4),
      .CLKS_PER_BIT (4)
   ) dut (
      .i_Clk        (clk),
      .i_Rst_L      (rst_n),
      .i_Req        (req),
      .i_Data       (data),
      .o_Ack        (ack),
      .o_Busy       (busy),
      .o_Active_Idx (act_idx),
      .o_UART_TX    (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Waits (bounded) for a nonzero ack, sampled on falling edges.
   task automatic wait_ack(input int limit, output logic [3:0] a,
                           output int at_cyc, output bit timeout);
      timeout = 1'b1;
      a       = '0;
      at_cyc  = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (ack !== 4'b0000) begin
            a       = ack;
            at_cyc  = cyc;
            timeout = 1'b0;
            break;
         end
      end
   endtask

   // Samples the line from the ack cycle (k=0) through the following
   // arbitration cycle (k=40), reconstructing the byte and frame shape.
   task automatic capture(output logic [7:0] b, output bit shape_ok,
                          output int busy_cnt, output int ack_cnt);
      b        = '0;
      shape_ok = 1'b1;
      busy_cnt = 0;
      ack_cnt  = 0;
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (ack !== 4'b0000) ack_cnt++;
         if (k < 4) begin
            if (tx !== 1'b0) shape_ok = 1'b0;
         end else if (k < 36) begin
            if ((k % 4) == 0) b[(k-4)/4] = tx;
            else if (tx !== b[(k-4)/4]) shape_ok = 1'b0;
         end else begin
            if (tx !== 1'b1) shape_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      req   = '0;
      data  = '0;
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b want=0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (act_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", act_idx); end
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || ack !== 4'b0000 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_50 bad_cycles=%0d want=0", bad); end
   endtask

   task automatic test_single();
      logic [3:0] a; int at; bit to; logic [7:0] b; bit ok; int bc, ac;
      data[7:0] = 8'hA5;
      req       = 4'b0001;
      wait_ack(5, a, at, to);
      req       = 4'b0000;
      data[7:0] = 8'hFF;
      checks++; if (to || a !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b timeout=%0d want=0001", a, to); end
      checks++; if (act_idx !== 2'd0) begin errors++; $display("FAIL single_idx got=%0d want=0", act_idx); end
      capture(b, ok, bc, ac);
      checks++; if (b !== 8'hA5) begin errors++; $display("FAIL single_byte got=%h want=a5", b); end
      checks++; if (!ok) begin errors++; $display("FAIL single_shape got=bad want=8N1"); end
      checks++; if (bc !== 40) begin errors++; $display("FAIL single_busy got=%0d want=40", bc); end
      checks++; if (ac !== 1) begin errors++; $display("FAIL single_ack_len got=%0d want=1", ac); end
   endtask

   task automatic test_rr_all();
      logic [3:0] a; int at, prev; bit to; logic [7:0] b; bit ok; int bc, ac;
      int         exp_i [5];
      logic [7:0] exp_b [5];
      exp_i = '{0, 1, 2, 3, 0};
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      data = 32'h4433_2211;
      req  = 4'b1111;
      prev = 0;
      for (int n = 0; n < 5; n++) begin
         wait_ack(50, a, at, to);
         if (n == 4) req = 4'b0000;
         checks++; if (to || a !== (4'b0001 << exp_i[n])) begin errors++; $display("FAIL rr_ack[%0d] got=%b want_idx=%0d", n, a, exp_i[n]); end
         if (n > 0) begin
            checks++; if (at - prev !== 41) begin errors++; $display("FAIL rr_spacing[%0d] got=%0d want=41", n, at - prev); end
         end
         prev = at;
         capture(b, ok, bc, ac);
         checks++; if (b !== exp_b[n] || !ok) begin errors++; $display("FAIL rr_byte[%0d] got=%h shape=%0d want=%h", n, b, ok, exp_b[n]); end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] a; int at; bit to; logic [7:0] b; bit ok; int bc, ac;
      req = 4'b0010;
      wait_ack(5, a, at, to);
      req = 4'b0011;
      checks++; if (to || a !== 4'b0010) begin errors++; $display("FAIL wrap_first got=%b want=0010", a); end
      capture(b, ok, bc, ac);
      wait_ack(5, a, at, to);
      checks++; if (to || a !== 4'b0001) begin errors++; $display("FAIL wrap_second got=%b want=0001", a); end
      checks++; if (act_idx !== 2'd0) begin errors++; $display("FAIL wrap_idx got=%0d want=0", act_idx); end
      capture(b, ok, bc, ac);
      checks++; if (b !== 8'h11 || !ok) begin errors++; $display("FAIL wrap_byte got=%h want=11", b); end
      wait_ack(5, a, at, to);
      req = 4'b0000;
      checks++; if (to || a !== 4'b0010) begin errors++; $display("FAIL wrap_third got=%b want=0010", a); end
      capture(b, ok, bc, ac);
      checks++; if (b !== 8'h22 || !ok) begin errors++; $display("FAIL wrap_byte3 got=%h want=22", b); end
   endtask

   task automatic test_drop();
      logic [3:0] a; int at; bit to; int acks, bad;
      data[7:0] = 8'h5A;
      req       = 4'b0001;
      wait_ack(5, a, at, to);
      req       = 4'b0000;
      checks++; if (to || a !== 4'b0001) begin errors++; $display("FAIL drop_ack0 got=%b want=0001", a); end
      acks = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ack !== 4'b0000) acks++;
         if (k == 10) req = 4'b0100;
         if (k == 20) req = 4'b0000;
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ack !== 4'b0000) acks++;
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++; if (acks !== 0) begin errors++; $display("FAIL drop_no_ack got=%0d want=0", acks); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL drop_line_idle bad=%0d want=0", bad); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] a; int at; bit to; logic [7:0] b; bit ok; int bc, ac;
      data[7:0] = 8'h00;
      req       = 4'b0001;
      wait_ack(5, a, at, to);
      req       = 4'b0000;
      checks++; if (to || a !== 4'b0001) begin errors++; $display("FAIL mid_ack got=%b want=0001", a); end
      repeat (17) @(negedge clk);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got=%b want=0", tx); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx got=%b want=1", tx); end
      checks++; if (busy !== 1'b0 || ack !== 4'b0000 || act_idx !== 2'd0) begin errors++; $display("FAIL mid_async_regs busy=%b ack=%b idx=%0d want=0", busy, ack, act_idx); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (ack !== 4'b0000 || tx !== 1'b1) begin errors++; $display("FAIL mid_no_replay ack=%b tx=%b want=0000/1", ack, tx); end
      data  = 32'h0077_00C3;
      req   = 4'b0101;
      wait_ack(5, a, at, to);
      req   = 4'b0000;
      checks++; if (to || a !== 4'b0001) begin errors++; $display("FAIL mid_ptr0 got=%b want=0001", a); end
      capture(b, ok, bc, ac);
      checks++; if (b !== 8'hC3 || !ok || bc !== 40) begin errors++; $display("FAIL mid_fresh got=%h shape=%0d busy=%0d want=c3/1/40", b, ok, bc); end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      data  = '0;
      test_reset();
      test_single();
      test_rr_all();
      test_wrap();
      test_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
